// File: rtl/adpll_gear_ctrl.sv
// adpll_gear_ctrl: ADPLL start-up sequencer and gain scheduler; define ADPLL_CTRL_RELOCK_EN to enable unlock detection in TRACK
module adpll_gear_ctrl #(
    parameter int                      PDET_WIDTH    = 8,
    parameter int                      KP_WIDTH      = 3,
    parameter int                      KI_WIDTH      = 4,
    parameter int                      WEIGHT_WIDTH  = 4,
    parameter logic [KP_WIDTH-1:0]     KP_ACQ        = 3'b100,
    parameter logic [KI_WIDTH-1:0]     KI_ACQ        = 4'b0100,
    parameter logic [KP_WIDTH-1:0]     KP_TRK        = 3'b010,
    parameter logic [KI_WIDTH-1:0]     KI_TRK        = 4'b0001,
    parameter logic [WEIGHT_WIDTH-1:0] WEIGHT_NOM    = 4'd2,
    parameter logic [PDET_WIDTH-1:0]   LOCK_THRESH   = 8'd4,
    parameter logic [PDET_WIDTH-1:0]   UNLOCK_THRESH = 8'd16,
    parameter int                      LOCK_COUNT    = 16,
    parameter int                      UNLOCK_COUNT  = 4,
    parameter int                      SETTLE_CYCLES = 256,
    parameter int                      CNT_WIDTH     = 10
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    sample_stb_i,
    input  logic [PDET_WIDTH-1:0]   error_i,
    output logic                    pll_reset_o,
    output logic                    pll_enable_o,
    output logic [KP_WIDTH-1:0]     kp_o,
    output logic [KI_WIDTH-1:0]     ki_o,
    output logic [WEIGHT_WIDTH-1:0] weight_left_o,
    output logic [WEIGHT_WIDTH-1:0] weight_above_o,
    output logic [WEIGHT_WIDTH-1:0] weight_right_o,
    output logic [WEIGHT_WIDTH-1:0] weight_below_o,
    output logic [1:0]              state_o,
    output logic                    locked_o,
    output logic                    lock_lost_o
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_ACQUIRE = 2'd2;
    localparam logic [1:0] S_TRACK   = 2'd3;
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CNT_WIDTH-1:0]  lock_cnt_q, lock_cnt_d;
    logic [PDET_WIDTH:0]   err_ext, mag;
    logic                  in_lock;

    // one extra bit so the most negative error has a representable magnitude
    assign err_ext = {error_i[PDET_WIDTH-1], error_i};
    assign mag     = error_i[PDET_WIDTH-1] ? -err_ext : err_ext;
    assign in_lock = mag <= {1'b0, LOCK_THRESH};

`ifdef ADPLL_CTRL_RELOCK_EN
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
    logic                 out_lock;
    logic [CNT_WIDTH-1:0] unlock_cnt_q, unlock_cnt_d;
    logic                 lock_lost_q, lock_lost_d;
    assign out_lock    = mag > {1'b0, UNLOCK_THRESH};
    assign lock_lost_o = lock_lost_q;
`else
    assign lock_lost_o = 1'b0;
`endif

    // next-state and counter update; a low enable overrides everything else
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = '0;
        lock_cnt_d   = lock_cnt_q;
`ifdef ADPLL_CTRL_RELOCK_EN
        unlock_cnt_d = '0;
        lock_lost_d  = 1'b0;
`endif
        if (!enable_i) begin
            state_d    = S_IDLE;
            lock_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            state_d    = S_SETTLE;
            lock_cnt_d = '0;
        end else if (state_q == S_SETTLE) begin
            settle_cnt_d = (settle_cnt_q >= SETTLE_LAST) ? '0 : settle_cnt_q + CNT_ONE;
            state_d      = (settle_cnt_q >= SETTLE_LAST) ? S_ACQUIRE : S_SETTLE;
        end else if (state_q == S_ACQUIRE) begin
            if (sample_stb_i) begin
                lock_cnt_d = !in_lock ? '0 : (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_ONE;
                state_d    = (in_lock && lock_cnt_q >= LOCK_LAST) ? S_TRACK : S_ACQUIRE;
            end
        end else begin
`ifdef ADPLL_CTRL_RELOCK_EN
            unlock_cnt_d = unlock_cnt_q;
            if (sample_stb_i) begin
                unlock_cnt_d = !out_lock ? '0 : (unlock_cnt_q == CNT_MAX) ? unlock_cnt_q : unlock_cnt_q + CNT_ONE;
                if (out_lock && unlock_cnt_q >= UNLOCK_LAST) begin
                    state_d      = S_ACQUIRE;
                    lock_lost_d  = 1'b1;
                    lock_cnt_d   = '0;
                    unlock_cnt_d = '0;
                end
            end
`endif
        end
    end

    // state and counter registers
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            lock_cnt_q   <= '0;
`ifdef ADPLL_CTRL_RELOCK_EN
            unlock_cnt_q <= '0;
            lock_lost_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
`ifdef ADPLL_CTRL_RELOCK_EN
            unlock_cnt_q <= unlock_cnt_d;
            lock_lost_q  <= lock_lost_d;
`endif
        end
    end

    assign state_o        = state_q;
    assign pll_reset_o    = state_q == S_IDLE;
    assign pll_enable_o   = state_q != S_IDLE;
    assign locked_o       = state_q == S_TRACK;
    assign kp_o           = (state_q == S_TRACK) ? KP_TRK : KP_ACQ;
    assign ki_o           = (state_q == S_TRACK) ? KI_TRK : KI_ACQ;
    assign weight_left_o  = (state_q == S_IDLE) ? '0 : WEIGHT_NOM;
    assign weight_above_o = (state_q == S_IDLE) ? '0 : WEIGHT_NOM;
    assign weight_right_o = (state_q == S_TRACK) ? WEIGHT_NOM : '0;
    assign weight_below_o = (state_q == S_TRACK) ? WEIGHT_NOM : '0;
endmodule

// File: tb/tb_adpll_gear_ctrl.sv
// tb_adpll_gear_ctrl: table-driven and randomized checks of adpll_gear_ctrl against a behavioural model
module tb_adpll_gear_ctrl;
`ifdef ADPLL_CTRL_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif
    localparam int IDLE = 0, SETTLE = 1, ACQ = 2, TRK = 3;

    typedef struct {
        bit e;
        bit s;
        int er;
        int reps;
        int st;
        bit lost;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b1, stb = 1'b0;
    logic [7:0] err = 8'd0;
    logic       pll_reset, pll_enable, locked, lock_lost;
    logic [2:0] kp;
    logic [3:0] ki, wl, wa, wr, wb;
    logic [1:0] state;
    logic [28:0] act;

    adpll_gear_ctrl dut (
        .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .sample_stb_i(stb), .error_i(err),
        .pll_reset_o(pll_reset), .pll_enable_o(pll_enable), .kp_o(kp), .ki_o(ki),
        .weight_left_o(wl), .weight_above_o(wa), .weight_right_o(wr), .weight_below_o(wb),
        .state_o(state), .locked_o(locked), .lock_lost_o(lock_lost)
    );

    assign act = {state, pll_reset, pll_enable, kp, ki, wl, wa, wr, wb, locked, lock_lost};

    always #5 clk = ~clk;

    int checks = 0, passes = 0;
    int m_state = IDLE, m_settle = 0;
    bit m_lost = 1'b0;
    bit hist[$];

    function automatic logic [28:0] exp_vec(int s, bit lost);
        case (s)
            IDLE:    return {2'd0, 1'b1, 1'b0, 3'b100, 4'b0100, 16'h0000, 1'b0, 1'b0};
            SETTLE:  return {2'd1, 1'b0, 1'b1, 3'b100, 4'b0100, 16'h2200, 1'b0, lost};
            ACQ:     return {2'd2, 1'b0, 1'b1, 3'b100, 4'b0100, 16'h2200, 1'b0, lost};
            default: return {2'd3, 1'b0, 1'b1, 3'b010, 4'b0001, 16'h2222, 1'b1, lost};
        endcase
    endfunction

    function automatic bit tail_all(int n);
        if (hist.size() < n) return 1'b0;
        for (int i = hist.size() - n; i < hist.size(); i++)
            if (!hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    // gear decisions from the recent sample history: a window of the last N strobes since entering the gear
    task automatic model_edge(bit e, bit s, int er);
        int mag;
        mag = (er < 0) ? -er : er;
        m_lost = 1'b0;
        if (!e) begin
            m_state = IDLE;
            hist.delete();
        end else if (m_state == IDLE) begin
            m_state = SETTLE;
            m_settle = 0;
        end else if (m_state == SETTLE) begin
            m_settle++;
            if (m_settle == 256) begin
                m_state = ACQ;
                hist.delete();
            end
        end else if (m_state == ACQ) begin
            if (s) begin
                hist.push_back(mag <= 4);
                if (tail_all(16)) begin
                    m_state = TRK;
                    hist.delete();
                end
            end
        end else if (RELOCK && s) begin
            hist.push_back(mag > 16);
            if (tail_all(4)) begin
                m_state = ACQ;
                m_lost = 1'b1;
                hist.delete();
            end
        end
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic check(string name, logic [28:0] a, logic [28:0] x);
        checks++;
        if (a === x) passes++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, a, x);
    endtask

    task automatic step(bit e, bit s, int er);
        en = e;
        stb = s;
        err = 8'(er);
        model_edge(e, s, er);
        @(posedge clk);
        @(negedge clk);
        check("model", act, exp_vec(m_state, m_lost));
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b1, 1'b1, 3, 15, ACQ, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 5, 1, ACQ, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 0, 15, ACQ, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 0, 1, TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 20, 1, TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 17, 1, TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 10, 1, TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 20, 3, TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 20, 1, RELOCK ? ACQ : TRK, RELOCK});
        tbl.push_back('{1'b1, 1'b0, 20, 1, RELOCK ? ACQ : TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 0, 15, RELOCK ? ACQ : TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, -128, 1, RELOCK ? ACQ : TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, -4, 15, RELOCK ? ACQ : TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b1, -4, 1, TRK, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 0, 3, TRK, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 100, 1, IDLE, 1'b0});

        @(negedge clk);
        check("reset_values", act, exp_vec(IDLE, 1'b0));
        rst = 1'b0;
        step(1'b1, 1'b0, 0);
        check("enter_settle", act, exp_vec(SETTLE, 1'b0));
        for (int i = 0; i < 255; i++) step(1'b1, (i % 3) == 0, 0);
        check("settle_255", {27'd0, state}, {27'd0, 2'd1});
        step(1'b1, 1'b0, 0);
        check("settle_to_acq", {27'd0, state}, {27'd0, 2'd2});

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) step(tbl[i].e, tbl[i].s, tbl[i].er);
            check($sformatf("tbl_row%0d", i), {26'd0, state, lock_lost}, {26'd0, 2'(tbl[i].st), tbl[i].lost});
        end

        begin
            bit quiet;
            quiet = 1'b1;
            for (int i = 0; i < 5000; i++) begin
                int er;
                if ($urandom_range(0, 39) == 0) quiet = ~quiet;
                er = quiet ? (int'($urandom_range(0, 8)) - 4) : (int'($urandom_range(0, 255)) - 128);
                step($urandom_range(0, 399) != 0, $urandom_range(0, 1) == 1, er);
                if ($urandom_range(0, 599) == 0) begin
                    rst = 1'b1;
                    m_state = IDLE;
                    m_lost = 1'b0;
                    hist.delete();
                    #2;
                    check("async_reset", act, exp_vec(IDLE, 1'b0));
                    rst = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/adpll_gear_ctrl.md
# adpll_gear_ctrl

Start-up and gain-scheduling controller for one network ADPLL node. It sequences the node's enable and reset and selects the loop-filter gains (kp/ki) and error-combiner weights. It moves the node from a wide-bandwidth acquisition gear to a narrow-bandwidth tracking gear by watching the node's signed phase error, and reports lock. It runs on the FPGA fabric clock and sits beside the node, driving its control inputs.

## Interface
Parameters:
- PDET_WIDTH, 8, phase-error width (signed)
- KP_WIDTH, 3; KI_WIDTH, 4; WEIGHT_WIDTH, 4, widths of the gain and weight buses
- KP_ACQ, 3'b100; KI_ACQ, 4'b0100, acquisition gains
- KP_TRK, 3'b010; KI_TRK, 4'b0001, tracking gains
- WEIGHT_NOM, 4'd2, neighbour weight in tracking
- LOCK_THRESH, 8'd4, |error| ≤ this counts as in-lock sample
- UNLOCK_THRESH, 8'd16, |error| > this counts as out-of-lock sample
- LOCK_COUNT, 16, consecutive in-lock samples to enter TRACK
- UNLOCK_COUNT, 4, consecutive out-of-lock samples to leave TRACK
- SETTLE_CYCLES, 256, fpga_clk cycles spent in SETTLE
- CNT_WIDTH, 10, width of the settle and sample counters; must hold SETTLE_CYCLES, LOCK_COUNT and UNLOCK_COUNT

Ports:
- fpga_clk_i  in  1  fabric clock
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  level; high requests node operation
- sample_stb_i  in  1  one-cycle pulse; error_i is valid this cycle
- error_i  in  PDET_WIDTH  signed combined phase error
- pll_reset_o  out  1  reset to node
- pll_enable_o  out  1  enable to node
- kp_o  out  KP_WIDTH  proportional gain
- ki_o  out  KI_WIDTH  integral gain
- weight_left_o, weight_above_o, weight_right_o, weight_below_o  out  WEIGHT_WIDTH each  combiner weights
- state_o  out  2  IDLE=0, SETTLE=1, ACQUIRE=2, TRACK=3
- locked_o  out  1  high in TRACK
- lock_lost_o  out  1  one-cycle pulse on TRACK→ACQUIRE

## Operation
- Magnitude: |error_i| is computed in PDET_WIDTH+1 bits, so −128 gives 128 with no overflow. Threshold comparisons are unsigned at that width.
- IDLE:
  - Outputs: pll_reset_o=1, pll_enable_o=0, acquisition gains, all weights 0, counters cleared.
  - Transition: enable_i=1 → SETTLE.
- SETTLE:
  - Outputs: pll_reset_o=0, pll_enable_o=1, acquisition gains, weight_left/above=WEIGHT_NOM, weight_right/below=0.
  - The settle counter counts fpga_clk cycles; sample strobes are ignored.
  - Transition: counter reaches SETTLE_CYCLES−1 → ACQUIRE.
- ACQUIRE:
  - Outputs: same as SETTLE.
  - Each strobe with |error| ≤ LOCK_THRESH increments the lock counter. Any other strobe clears it.
  - Transition: the LOCK_COUNT-th consecutive in-lock strobe → TRACK.
- TRACK:
  - Outputs: tracking gains, all four weights = WEIGHT_NOM, locked_o=1.
  - Each strobe with |error| > UNLOCK_THRESH increments the unlock counter. Any other strobe clears it.
  - Transition: the UNLOCK_COUNT-th consecutive out-of-lock strobe → ACQUIRE, pulses lock_lost_o and clears the lock counter (only when ADPLL_CTRL_RELOCK_EN is defined).
- Boundary conditions:
  - enable_i=0 in any state → IDLE on the next edge. This has priority over any strobe in the same cycle. No lock_lost_o pulse.
  - Samples with LOCK_THRESH < |error| ≤ UNLOCK_THRESH in TRACK clear the unlock counter (hysteresis band).
  - Counters saturate and never wrap.
  - Strobes in IDLE are ignored.

## Timing
- All outputs are registered and decoded from the state register. They change on the same edge as the state.
- Latency: a qualifying strobe at edge N changes state and outputs at edge N+1.
- The SETTLE→ACQUIRE transition occurs exactly SETTLE_CYCLES edges after entering SETTLE.
- Reset values: state IDLE, pll_reset_o=1, pll_enable_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ, weights 0, locked_o=0, lock_lost_o=0, counters 0.
- Reset mid-operation forces these values immediately (asynchronously), regardless of state.

## Configuration
- ADPLL_CTRL_RELOCK_EN defined: unlock detection in TRACK is active as described.
- ADPLL_CTRL_RELOCK_EN undefined:
  - TRACK is sticky until enable_i falls or reset.
  - The unlock counter is not built; lock_lost_o is tied to 0.

## Test plan
- Reset with enable_i=1, then release → IDLE one edge; SETTLE with pll_enable_o=1 and kp_o=3'b100; ACQUIRE after 256 cycles.
- In ACQUIRE, 16 strobes with error_i=−4 → TRACK one edge after the 16th strobe; kp_o=3'b010, ki_o=4'b0001, all weights 2, locked_o=1.
- In ACQUIRE, 15 strobes with error 3, one with error 5, then 15 with error 0 → stays in ACQUIRE; one more strobe with error 0 → TRACK.
- In TRACK, strobes with errors 20, 17, 10, 20, 20, 20, 20 → stays in TRACK through the 10 (counter cleared). The last 20 moves to ACQUIRE with a one-cycle lock_lost_o (RELOCK_EN). Without RELOCK_EN it stays in TRACK.
- In ACQUIRE, strobe with error_i=−128 → counted as out-of-lock, lock counter cleared.
- In TRACK, drop enable_i in the same cycle as a strobe with error 100 → IDLE next edge, lock_lost_o stays 0, pll_reset_o=1.
